// File: rtl/cv32e40p_error_manager.sv
// ============================================================================
// Module   : cv32e40p_error_manager
// Brief    : Collects masked fault-detector flags, raises a fault interrupt,
//            and enforces a quiet holdoff period after the acknowledge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cv32e40p_error_manager #(
    parameter int NUM_ERR        = 48,
    parameter int CNT_W          = 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_ERR-1:0]         err_i,
    input  logic [NUM_ERR-1:0]         err_mask_i,
    input  logic                       clear_i,
    input  logic                       irq_ack_i,
    output logic                       irq_o,
    output logic                       busy_o,
    output logic [NUM_ERR-1:0]         err_status_o,
    output logic [$clog2(NUM_ERR)-1:0] first_err_id_o,
    output logic [CNT_W-1:0]           err_count_o,
    output logic                       overflow_o
);

    localparam int             ID_W           = $clog2(NUM_ERR);
    localparam logic [7:0]     C_HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NOTIFY  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t            r_state,  w_state_next;
    logic [7:0]        r_timer,  w_timer_next;
    logic              r_irq,    w_irq_next;
    logic              r_busy,   w_busy_next;
    logic [NUM_ERR-1:0] r_status, w_status_next;
    logic [ID_W-1:0]   r_first_id, w_first_id_next;
    logic [CNT_W-1:0]  r_count,  w_count_next;
    logic              r_ovf,    w_ovf_next;

    logic [NUM_ERR-1:0] w_act;
    logic               w_any_err;
    logic               w_capture;
    logic               w_late_err;
    logic [ID_W-1:0]    w_low_id;

    assign w_act      = err_i & ~err_mask_i;
    assign w_any_err  = |w_act;
    assign w_capture  = (r_state == ST_IDLE) && w_any_err;
    assign w_late_err = (r_state != ST_IDLE) && w_any_err;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        w_low_id = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_low_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (w_any_err) begin
                    w_state_next = ST_NOTIFY;
                end
            end
            ST_NOTIFY: begin
                if (irq_ack_i) begin
                    w_state_next = ST_HOLDOFF;
                    w_timer_next = C_HOLDOFF_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (r_timer == 8'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_timer_next = r_timer - 8'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_timer_next = 8'd0;
            end
        endcase

        // irq drops on the acknowledging edge and rises one edge after capture.
        w_irq_next  = (r_state == ST_NOTIFY) && (w_state_next == ST_NOTIFY);
        w_busy_next = (w_state_next != ST_IDLE);

        w_status_next = (clear_i ? '0 : r_status) | w_act;

        if (clear_i) begin
            w_count_next    = w_capture ? CNT_W'(1) : '0;
            w_first_id_next = w_capture ? w_low_id : '0;
            w_ovf_next      = w_late_err;
        end else begin
            w_count_next    = r_count;
            w_first_id_next = r_first_id;
            w_ovf_next      = r_ovf | w_late_err;
            if (w_capture) begin
                w_first_id_next = w_low_id;
                if (r_count != C_CNT_MAX) begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_timer    <= 8'd0;
            r_irq      <= 1'b0;
            r_busy     <= 1'b0;
            r_status   <= '0;
            r_first_id <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_irq      <= w_irq_next;
            r_busy     <= w_busy_next;
            r_status   <= w_status_next;
            r_first_id <= w_first_id_next;
            r_count    <= w_count_next;
            r_ovf      <= w_ovf_next;
        end
    end

    assign irq_o          = r_irq;
    assign busy_o         = r_busy;
    assign err_status_o   = r_status;
    assign first_err_id_o = r_first_id;
    assign err_count_o    = r_count;
    assign overflow_o     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_error_manager.sv
// ============================================================================
// Module   : tb_cv32e40p_error_manager
// Brief    : Directed vector table, saturation sequence and randomized run
//            against a behavioural model of the error manager.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cv32e40p_error_manager;

    localparam int NE   = 48;
    localparam int CW   = 2;
    localparam int HOLD = 4;
    localparam logic [NE-1:0] ONE = 48'd1;

    logic          clk = 1'b0;
    logic          rst, clr, ack;
    logic [NE-1:0] err, mask;
    logic          irq, busy, ovf;
    logic [NE-1:0] st;
    logic [5:0]    id;
    logic [CW-1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40p_error_manager #(
        .NUM_ERR(NE), .CNT_W(CW), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .err_i(err), .err_mask_i(mask),
        .clear_i(clr), .irq_ack_i(ack), .irq_o(irq), .busy_o(busy),
        .err_status_o(st), .first_err_id_o(id), .err_count_o(cnt),
        .overflow_o(ovf)
    );

    typedef struct {
        logic rst, clr, ack;
        logic [NE-1:0] err, mask;
        logic e_irq, e_busy, e_ovf;
        logic [NE-1:0] e_st;
        logic [5:0] e_id;
        logic [CW-1:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, c, a, input logic [NE-1:0] e, m,
                                input logic ei, eb, eo, input logic [NE-1:0] es,
                                input int eid, input int ec);
        vec_t v;
        v.rst = r; v.clr = c; v.ack = a; v.err = e; v.mask = m;
        v.e_irq = ei; v.e_busy = eb; v.e_ovf = eo; v.e_st = es;
        v.e_id = 6'(eid); v.e_cnt = CW'(ec);
        return v;
    endfunction

    task automatic check(input string nm, input logic ei, eb, eo,
                         input logic [NE-1:0] es, input logic [5:0] eid,
                         input logic [CW-1:0] ec);
        n_tests++;
        if ({irq, busy, ovf, st, id, cnt} !== {ei, eb, eo, es, eid, ec}) begin
            n_fail++;
            $display("FAIL %s: got irq=%0b busy=%0b ovf=%0b status=%h id=%0d cnt=%0d, expected irq=%0b busy=%0b ovf=%0b status=%h id=%0d cnt=%0d",
                     nm, irq, busy, ovf, st, id, cnt, ei, eb, eo, es, eid, ec);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: "waiting for ack" flag plus a count of remaining quiet cycles.
    logic          m_wait, m_irq, m_ovf;
    int            m_quiet, m_cnt, m_id;
    logic [NE-1:0] m_st;

    task automatic model_edge();
        logic [NE-1:0] act;
        logic quiet_now, cap, late;
        int low;
        if (rst) begin
            m_wait = 0; m_irq = 0; m_quiet = 0; m_st = '0; m_cnt = 0; m_id = 0; m_ovf = 0;
            return;
        end
        act = err & ~mask;
        quiet_now = !m_wait && (m_quiet == 0);
        cap  = quiet_now && (act != '0);
        late = !quiet_now && (act != '0);
        low = 0;
        for (int i = NE - 1; i >= 0; i--) if (act[i]) low = i;
        m_st = (clr ? '0 : m_st) | act;
        if (clr) begin
            m_cnt = cap ? 1 : 0;
            m_id  = cap ? low : 0;
            m_ovf = late;
        end else begin
            if (cap) begin
                m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
                m_id  = low;
            end
            m_ovf = m_ovf | late;
        end
        m_irq = 0;
        if (m_wait) begin
            if (ack) begin m_wait = 0; m_quiet = HOLD; end
            else m_irq = 1;
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (cap) begin
            m_wait = 1;
        end
    endtask

    vec_t tbl[$];

    initial begin
        logic [NE-1:0] b3_40, prev_err;
        int sel;
        b3_40 = (ONE << 3) | (ONE << 40);
        rst = 1; clr = 0; ack = 0; err = '0; mask = '0;

        tbl.push_back(mk(1,0,0, '0,       '0,       0,0,0, '0,                0, 0)); // reset
        tbl.push_back(mk(0,0,0, ONE<<5,   '0,       0,1,0, ONE<<5,            5, 1)); // single error
        tbl.push_back(mk(0,0,0, '0,       '0,       1,1,0, ONE<<5,            5, 1)); // irq rises
        tbl.push_back(mk(0,0,1, '0,       '0,       0,1,0, ONE<<5,            5, 1)); // ack
        tbl.push_back(mk(0,0,0, ONE<<7,   '0,       0,1,1, (ONE<<5)|(ONE<<7), 5, 1)); // late error
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,1, (ONE<<5)|(ONE<<7), 5, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,1, (ONE<<5)|(ONE<<7), 5, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,0,1, (ONE<<5)|(ONE<<7), 5, 1)); // back to idle
        tbl.push_back(mk(0,1,0, '0,       '0,       0,0,0, '0,                0, 0)); // clear
        tbl.push_back(mk(0,0,0, b3_40,    '0,       0,1,0, b3_40,             3, 1)); // simultaneous
        tbl.push_back(mk(0,0,1, '0,       '0,       0,1,0, b3_40,             3, 1)); // early ack
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,0, b3_40,             3, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,0, b3_40,             3, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,0, b3_40,             3, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,0,0, b3_40,             3, 1));
        tbl.push_back(mk(0,0,0, ONE<<9,   ONE<<9,   0,0,0, b3_40,             3, 1)); // masked
        tbl.push_back(mk(0,1,0, '0,       '0,       0,0,0, '0,                0, 0));
        tbl.push_back(mk(0,0,0, ONE<<5,   '0,       0,1,0, ONE<<5,            5, 1));
        tbl.push_back(mk(0,0,1, '0,       '0,       0,1,0, ONE<<5,            5, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,0, ONE<<5,            5, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,0, ONE<<5,            5, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,1,0, ONE<<5,            5, 1));
        tbl.push_back(mk(0,0,0, '0,       '0,       0,0,0, ONE<<5,            5, 1));
        tbl.push_back(mk(0,1,0, ONE<<1,   '0,       0,1,0, ONE<<1,            1, 1)); // clear collision
        tbl.push_back(mk(0,0,0, '0,       '0,       1,1,0, ONE<<1,            1, 1));
        tbl.push_back(mk(1,0,0, ONE<<1,   '0,       0,0,0, '0,                0, 0)); // reset mid-NOTIFY
        tbl.push_back(mk(0,0,0, ONE<<1,   '0,       0,1,0, ONE<<1,            1, 1));
        tbl.push_back(mk(1,0,0, '0,       '0,       0,0,0, '0,                0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; clr = tbl[i].clr; ack = tbl[i].ack;
            err = tbl[i].err; mask = tbl[i].mask;
            step();
            check($sformatf("vec%0d", i), tbl[i].e_irq, tbl[i].e_busy, tbl[i].e_ovf,
                  tbl[i].e_st, tbl[i].e_id, tbl[i].e_cnt);
        end

        // Saturation: four capture/ack rounds with a 2-bit counter.
        rst = 0; clr = 0; ack = 0; err = '0; mask = '0;
        for (int k = 1; k <= 4; k++) begin
            err = ONE << 2; step(); err = '0;
            step();
            ack = 1; step(); ack = 0;
            for (int j = 0; j < HOLD; j++) step();
            check($sformatf("sat%0d", k), 0, 0, 0, ONE << 2, 6'd2, CW'(k < 3 ? k : 3));
        end

        // Randomized run against the model.
        rst = 1; step(); model_edge();
        prev_err = '0;
        for (int c = 0; c < 2000; c++) begin
            sel = $urandom_range(0, 7);
            if (sel < 4)       err = '0;
            else if (sel == 4) err = prev_err;
            else if (sel < 7)  err = ONE << $urandom_range(0, NE - 1);
            else               err = (ONE << $urandom_range(0, NE - 1)) | (ONE << $urandom_range(0, NE - 1));
            prev_err = err;
            if ($urandom_range(0, 15) == 0)
                mask = 48'({$urandom(), $urandom()}) & 48'({$urandom(), $urandom()})
                     & 48'({$urandom(), $urandom()});
            ack = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
            model_edge();
            check($sformatf("rnd%0d", c), m_irq, m_wait || (m_quiet > 0), m_ovf,
                  m_st, 6'(m_id), CW'(m_cnt));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
